branch_cond_gen: RTL and testbench
==================================

// Module: branch_cond_gen
// PURPOSE
//  Branch condition generator for the RV32 execute stage. Compares rs1/rs2 and
//  produces combinational eq/lt/ltu flags, used by the control decoder in the
//  same cycle. Also decodes branch func3 into a taken/illegal decision and
//  registers it, with a valid flag, for downstream pipeline and trace logic.
// PARAMETERS
//  XLEN  32  operand width in bits; must be >= 2
// PORTS
//  clk         in   1     single clock; all state updates on rising edge
//  rst         in   1     synchronous reset, active-high
//  rs1         in   XLEN  operand 1, register file read port A
//  rs2         in   XLEN  operand 2, register file read port B
//  func3       in   3     branch func3 field, instr[14:12]
//  br_valid    in   1     current instruction is a BRANCH (opcode 0x63)
//  br_eq       out  1     comb: rs1 == rs2
//  br_lt       out  1     comb: signed rs1 < rs2
//  br_ltu      out  1     comb: unsigned rs1 < rs2
//  br_taken    out  1     comb: branch condition true for func3 (0 if !br_valid)
//  br_illegal  out  1     comb: br_valid && func3 in {010,011}
//  taken_q     out  1     registered br_taken
//  illegal_q   out  1     registered br_illegal
//  valid_q     out  1     registered br_valid
// BEHAVIOUR
//  - br_eq/br_lt/br_ltu are purely combinational, independent of clk/rst/br_valid.
//  - br_lt is a two's-complement compare over XLEN bits; br_ltu is a magnitude compare.
//  - func3 decode (only when br_valid=1): 000 BEQ=eq; 001 BNE=!eq; 100 BLT=lt;
//    101 BGE=!lt; 110 BLTU=ltu; 111 BGEU=!ltu; 010/011 -> taken=0, illegal=1.
//  - br_valid=0: br_taken=0, br_illegal=0, whatever func3 is.
//  - Registered outputs: 1-cycle latency. Each rising edge with rst=0 loads
//    taken_q<=br_taken, illegal_q<=br_illegal, valid_q<=br_valid.
//  - rst=1 at a rising edge: taken_q=0, illegal_q=0, valid_q=0 (and counters=0);
//    comb outputs keep tracking inputs during reset. Reset wins over any valid input.
//  - No handshake, no stall: a new evaluation is accepted every cycle.
//  - Boundaries: rs1=rs2 -> eq=1, lt=0, ltu=0. rs1=0x80000000, rs2=0x7FFFFFFF ->
//    lt=1, ltu=0. rs1=0xFFFFFFFF, rs2=0 -> lt=1, ltu=0.
// CONFIGURATION
//  BRCOND_STATS_EN defined: adds outputs br_count[31:0] and taken_count[31:0].
//    Each cycle with rst=0 and br_valid=1 (and br_illegal=0), br_count increments.
//    taken_count also increments when br_taken=1. Both wrap from 0xFFFFFFFF to 0.
//    Both are 0 after reset. Illegal func3 cycles increment neither counter.
//  BRCOND_STATS_EN undefined: counters and their ports are absent; all other
//    behaviour is identical.
// TESTING
//  1. rs1=5, rs2=5, func3=000, br_valid=1 -> eq=1, lt=0, ltu=0, br_taken=1;
//     taken_q=1 one cycle later.
//  2. rs1=0xFFFFFFFF, rs2=1, func3=100 -> lt=1, taken=1; func3=110 -> ltu=0, taken=0;
//     func3=111 -> taken=1.
//  3. rs1=0x80000000, rs2=0x7FFFFFFF, func3=101 (BGE) -> taken=0;
//     func3=111 (BGEU) -> taken=1.
//  4. func3=010, br_valid=1 -> br_illegal=1, br_taken=0; with br_valid=0 -> both 0.
//  5. Drive valid taken branches for 3 cycles, then assert rst=1 for 1 edge ->
//     taken_q=valid_q=0 after that edge, while comb flags still follow rs1/rs2.
//  6. BRCOND_STATS_EN: 4 valid branches, 2 taken, 1 illegal -> br_count=4,
//     taken_count=2. Preload via force to 0xFFFFFFFF, apply one valid branch ->
//     br_count=0.

Source files
------------

// File: rtl/branch_cond_gen.sv
// RV32 branch condition generator: combinational compare flags, func3 decode and registered result.
// Optional BRCOND_STATS_EN adds free-running branch/taken counters.
module branch_cond_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func3,
  input  logic            br_valid,
  output logic            br_eq,
  output logic            br_lt,
  output logic            br_ltu,
  output logic            br_taken,
  output logic            br_illegal,
  output logic            taken_q,
  output logic            illegal_q,
  output logic            valid_q
`ifdef BRCOND_STATS_EN
  ,
  output logic [31:0]     br_count,
  output logic [31:0]     taken_count
`endif
);

  assign br_eq  = (rs1 == rs2);
  assign br_lt  = ($signed(rs1) < $signed(rs2));
  assign br_ltu = (rs1 < rs2);

  always_comb begin
    br_taken   = 1'b0;
    br_illegal = 1'b0;
    if (br_valid) begin
      case (func3)
        3'b000:  br_taken = br_eq;
        3'b001:  br_taken = ~br_eq;
        3'b100:  br_taken = br_lt;
        3'b101:  br_taken = ~br_lt;
        3'b110:  br_taken = br_ltu;
        3'b111:  br_taken = ~br_ltu;
        default: br_illegal = 1'b1;
      endcase
    end
  end

  logic taken_d, illegal_d, valid_d;

  always_comb begin
    taken_d   = br_taken;
    illegal_d = br_illegal;
    valid_d   = br_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

`ifdef BRCOND_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] taken_count_q, taken_count_d;

  // Only legal branches are counted; both counters wrap naturally.
  always_comb begin
    br_count_d    = br_count_q;
    taken_count_d = taken_count_q;
    if (br_valid && !br_illegal) begin
      br_count_d = br_count_q + 32'd1;
      if (br_taken) begin
        taken_count_d = taken_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q    <= 32'd0;
      taken_count_q <= 32'd0;
    end else begin
      br_count_q    <= br_count_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign br_count    = br_count_q;
  assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_cond_gen.sv
// Directed self-checking bench for branch_cond_gen; covers stats counters when BRCOND_STATS_EN is set.
module tb_branch_cond_gen;

  logic        clk;
  logic        rst;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  func3;
  logic        br_valid;
  logic        br_eq, br_lt, br_ltu, br_taken, br_illegal;
  logic        taken_q, illegal_q, valid_q;
`ifdef BRCOND_STATS_EN
  logic [31:0] br_count, taken_count;
`endif

  int n_cmp;
  int n_fail;

  branch_cond_gen #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .func3      (func3),
    .br_valid   (br_valid),
    .br_eq      (br_eq),
    .br_lt      (br_lt),
    .br_ltu     (br_ltu),
    .br_taken   (br_taken),
    .br_illegal (br_illegal),
    .taken_q    (taken_q),
    .illegal_q  (illegal_q),
    .valid_q    (valid_q)
`ifdef BRCOND_STATS_EN
    ,
    .br_count   (br_count),
    .taken_count(taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                       input logic v);
    rs1      = a;
    rs2      = b;
    func3    = f;
    br_valid = v;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'd1, 32'd1, 3'b000, 1'b1);
    tick();
    n_cmp++;
    if ({taken_q, illegal_q, valid_q} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_regs: got %b expected 000", {taken_q, illegal_q, valid_q});
    end
    // comb flags track inputs during reset: {eq,lt,ltu,taken,illegal}
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, br_illegal} !== 5'b10010) begin
      n_fail++;
      $display("FAIL reset_comb: got %b expected 10010",
               {br_eq, br_lt, br_ltu, br_taken, br_illegal});
    end
`ifdef BRCOND_STATS_EN
    n_cmp++;
    if ({br_count, taken_count} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h/%h expected 0/0", br_count, taken_count);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_beq();
    drive(32'd5, 32'd5, 3'b000, 1'b1);
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, br_illegal} !== 5'b10010) begin
      n_fail++;
      $display("FAIL beq_comb: got %b expected 10010",
               {br_eq, br_lt, br_ltu, br_taken, br_illegal});
    end
    tick();
    n_cmp++;
    if ({taken_q, illegal_q, valid_q} !== 3'b101) begin
      n_fail++;
      $display("FAIL beq_regs: got %b expected 101", {taken_q, illegal_q, valid_q});
    end
  endtask

  task automatic test_signed_unsigned();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [2:0]  vf [6];
    logic [4:0]  exp [6];
    // {eq,lt,ltu,taken,illegal}
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'd1;          vf[0] = 3'b100; exp[0] = 5'b01010;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'd1;          vf[1] = 3'b110; exp[1] = 5'b01000;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'd1;          vf[2] = 3'b111; exp[2] = 5'b01010;
    va[3] = 32'h8000_0000; vb[3] = 32'h7FFF_FFFF; vf[3] = 3'b101; exp[3] = 5'b01000;
    va[4] = 32'h8000_0000; vb[4] = 32'h7FFF_FFFF; vf[4] = 3'b111; exp[4] = 5'b01010;
    va[5] = 32'hFFFF_FFFF; vb[5] = 32'd0;          vf[5] = 3'b001; exp[5] = 5'b01010;
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i], vf[i], 1'b1);
      n_cmp++;
      if ({br_eq, br_lt, br_ltu, br_taken, br_illegal} !== exp[i]) begin
        n_fail++;
        $display("FAIL signed_vec%0d: got %b expected %b", i,
                 {br_eq, br_lt, br_ltu, br_taken, br_illegal}, exp[i]);
      end
    end
  endtask

  task automatic test_func3_decode();
    // rs1=3, rs2=7: eq=0 lt=1 ltu=1; expected {taken,illegal} per func3 0..7
    logic [1:0] exp [8];
    exp[0] = 2'b00; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b01;
    exp[4] = 2'b10; exp[5] = 2'b00; exp[6] = 2'b10; exp[7] = 2'b00;
    for (int i = 0; i < 8; i++) begin
      drive(32'd3, 32'd7, 3'(i), 1'b1);
      n_cmp++;
      if ({br_eq, br_lt, br_ltu, br_taken, br_illegal} !== {3'b011, exp[i]}) begin
        n_fail++;
        $display("FAIL decode_f%0d: got %b expected %b", i,
                 {br_eq, br_lt, br_ltu, br_taken, br_illegal}, {3'b011, exp[i]});
      end
    end
  endtask

  task automatic test_illegal();
    drive(32'd9, 32'd2, 3'b010, 1'b1);
    n_cmp++;
    if ({br_taken, br_illegal} !== 2'b01) begin
      n_fail++;
      $display("FAIL illegal_comb: got %b expected 01", {br_taken, br_illegal});
    end
    tick();
    n_cmp++;
    if ({taken_q, illegal_q, valid_q} !== 3'b011) begin
      n_fail++;
      $display("FAIL illegal_regs: got %b expected 011", {taken_q, illegal_q, valid_q});
    end
    drive(32'd9, 32'd2, 3'b010, 1'b0);
    n_cmp++;
    if ({br_taken, br_illegal} !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal_novalid: got %b expected 00", {br_taken, br_illegal});
    end
    // BNE with 9!=2 would be taken, but not a branch
    drive(32'd9, 32'd2, 3'b001, 1'b0);
    n_cmp++;
    if ({br_eq, br_lt, br_ltu, br_taken, br_illegal} !== 5'b00000) begin
      n_fail++;
      $display("FAIL novalid_bne: got %b expected 00000",
               {br_eq, br_lt, br_ltu, br_taken, br_illegal});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [2:0]  vf [4];
    logic        vv [4];
    logic [2:0]  exp [4];
    // expected {taken_q,illegal_q,valid_q} after each edge
    va[0] = 32'd1; vb[0] = 32'd2; vf[0] = 3'b100; vv[0] = 1'b1; exp[0] = 3'b101;
    va[1] = 32'd1; vb[1] = 32'd2; vf[1] = 3'b011; vv[1] = 1'b1; exp[1] = 3'b011;
    va[2] = 32'd4; vb[2] = 32'd4; vf[2] = 3'b000; vv[2] = 1'b0; exp[2] = 3'b000;
    va[3] = 32'd4; vb[3] = 32'd4; vf[3] = 3'b111; vv[3] = 1'b1; exp[3] = 3'b101;
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], vf[i], vv[i]);
      tick();
      n_cmp++;
      if ({taken_q, illegal_q, valid_q} !== exp[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %b expected %b", i, {taken_q, illegal_q, valid_q}, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drive(32'd10, 32'd20, 3'b110, 1'b1);
      tick();
    end
    n_cmp++;
    if ({taken_q, valid_q} !== 2'b11) begin
      n_fail++;
      $display("FAIL pre_reset: got %b expected 11", {taken_q, valid_q});
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({taken_q, illegal_q, valid_q} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset_regs: got %b expected 000", {taken_q, illegal_q, valid_q});
    end
    drive(32'd20, 32'd20, 3'b110, 1'b1);
    n_cmp++;
    if ({br_eq, br_lt, br_ltu} !== 3'b100) begin
      n_fail++;
      $display("FAIL mid_reset_comb: got %b expected 100", {br_eq, br_lt, br_ltu});
    end
    rst = 1'b0;
  endtask

`ifdef BRCOND_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(32'd1, 32'd1, 3'b000, 1'b1); tick();  // taken
    drive(32'd1, 32'd1, 3'b001, 1'b1); tick();  // not taken
    drive(32'd1, 32'd1, 3'b010, 1'b1); tick();  // illegal
    drive(32'd1, 32'd2, 3'b110, 1'b1); tick();  // taken
    drive(32'd1, 32'd2, 3'b000, 1'b0); tick();  // not a branch
    drive(32'd1, 32'd2, 3'b111, 1'b1); tick();  // not taken
    n_cmp++;
    if ({br_count, taken_count} !== {32'd4, 32'd2}) begin
      n_fail++;
      $display("FAIL stats_counts: got %0d/%0d expected 4/2", br_count, taken_count);
    end
    force dut.br_count_q    = 32'hFFFF_FFFF;
    force dut.taken_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    release dut.taken_count_q;
    drive(32'd7, 32'd7, 3'b000, 1'b1);
    tick();
    n_cmp++;
    if ({br_count, taken_count} !== 64'd0) begin
      n_fail++;
      $display("FAIL stats_wrap: got %h/%h expected 0/0", br_count, taken_count);
    end
  endtask
`endif

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rs1      = '0;
    rs2      = '0;
    func3    = '0;
    br_valid = 1'b0;
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_func3_decode();
    test_illegal();
    test_back_to_back();
    test_reset_midstream();
`ifdef BRCOND_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
